// File: rtl/mem_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_slot_arbiter_pkg
//  Purpose  : Shared grant indices, slot phase codes and round-robin pointer
//             type for the memory slot arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_slot_arbiter_pkg;

    localparam int G_VID = 0;
    localparam int G_DSP = 1;
    localparam int G_BLT = 2;
    localparam int G_CPU = 3;

    localparam logic [1:0] PH_A = 2'd0;
    localparam logic [1:0] PH_B = 2'd1;
    localparam logic [1:0] PH_C = 2'd2;

    typedef enum logic {
        RR_BLT_NEXT = 1'b0,
        RR_CPU_NEXT = 1'b1
    } rr_ptr_t;

    function automatic logic [3:0] grant_onehot(input int idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_slot_arbiter_if
//  Purpose  : Requester/arbiter bundle: level requests in, one-tick acks,
//             one-hot slot grant and phase status out.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_slot_arbiter_if;
    logic       VIDREQ;
    logic       DSPREQ;
    logic       BLTREQ;
    logic       BLTLOCK;
    logic       CPUREQ;
    logic       VIDACK;
    logic       DSPACK;
    logic       BLTACK;
    logic       CPUACK;
    logic [3:0] GNT;
    logic [1:0] PHASE;
    logic       CYCSTART;
    logic       BUSY;

    modport slave (
        input  VIDREQ, DSPREQ, BLTREQ, BLTLOCK, CPUREQ,
        output VIDACK, DSPACK, BLTACK, CPUACK, GNT, PHASE, CYCSTART, BUSY
    );

    modport master (
        output VIDREQ, DSPREQ, BLTREQ, BLTLOCK, CPUREQ,
        input  VIDACK, DSPACK, BLTACK, CPUACK, GNT, PHASE, CYCSTART, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/mem_slot_arbiter_slot_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module   : slot_phase_counter
//  Purpose  : Mod-3 slot phase counter with slot-start and arbitrate strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module slot_phase_counter
    import mem_slot_arbiter_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    output logic [1:0]      o_phase,
    output logic            o_cycstart,
    output logic            o_arb
);
    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q + 2'd1;
        if (phase_q == PH_C) begin
            phase_d = PH_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_A;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign o_phase    = phase_q;
    assign o_cycstart = (phase_q == PH_A);
    assign o_arb      = (phase_q == PH_C);
endmodule
`default_nettype wire

// File: rtl/mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_slot_arbiter
//  Purpose  : Per-slot owner selection for VID/DSP/BLT/CPU with a BLT/CPU
//             round robin, bounded blitter burst lock and one-tick acks.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_slot_arbiter
    import mem_slot_arbiter_pkg::*;
#(
    parameter int MAXBURST = 4,
    parameter int BCW      = 4
) (
    input  wire logic          MCK,
    input  wire logic          RESET,
    mem_slot_arbiter_if.slave  bus
);
    localparam logic [BCW-1:0] C_BURST_LIM = BCW'(MAXBURST - 1);

    logic [1:0]     w_phase;
    logic           w_cycstart;
    logic           w_arb;
    logic [3:0]     w_req;
    logic [3:0]     w_win;
    logic           w_retain;
    rr_ptr_t        w_rr_win;

    logic [3:0]     gnt_q,   gnt_d;
    logic [3:0]     ack_q,   ack_d;
    rr_ptr_t        rr_q,    rr_d;
    logic [BCW-1:0] burst_q, burst_d;

    slot_phase_counter u_phase (
        .clk        (MCK),
        .rst        (RESET),
        .o_phase    (w_phase),
        .o_cycstart (w_cycstart),
        .o_arb      (w_arb)
    );

    assign w_req = {bus.CPUREQ, bus.BLTREQ, bus.DSPREQ, bus.VIDREQ};

    // Winner proposal; only committed on the PHASE==2 edge.
    always_comb begin
        w_win    = 4'b0000;
        w_rr_win = rr_q;
        w_retain = gnt_q[G_BLT] & bus.BLTLOCK & w_req[G_BLT] & (burst_q < C_BURST_LIM);
        if (w_req[G_VID]) begin
            w_win = grant_onehot(G_VID);
        end else if (w_retain) begin
            w_win = grant_onehot(G_BLT);
        end else if (w_req[G_DSP]) begin
            w_win = grant_onehot(G_DSP);
        end else if (w_req[G_BLT] && (!w_req[G_CPU] || rr_q == RR_BLT_NEXT)) begin
            w_win    = grant_onehot(G_BLT);
            w_rr_win = RR_CPU_NEXT;
        end else if (w_req[G_CPU]) begin
            w_win    = grant_onehot(G_CPU);
            w_rr_win = RR_BLT_NEXT;
        end
    end

    always_comb begin
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        ack_d   = gnt_q & w_req & {4{w_arb}};
        if (w_arb) begin
            gnt_d = w_win;
            rr_d  = w_rr_win;
            // Counts slots BLT holds beyond its first; saturation ends a lock.
            if (w_win[G_BLT] && gnt_q[G_BLT]) begin
                if (burst_q < C_BURST_LIM) begin
                    burst_d = burst_q + BCW'(1);
                end
            end else begin
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge MCK or posedge RESET) begin
        if (RESET) begin
            gnt_q   <= 4'b0000;
            ack_q   <= 4'b0000;
            rr_q    <= RR_CPU_NEXT;
            burst_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.VIDACK   = ack_q[G_VID];
    assign bus.DSPACK   = ack_q[G_DSP];
    assign bus.BLTACK   = ack_q[G_BLT];
    assign bus.CPUACK   = ack_q[G_CPU];
    assign bus.PHASE    = w_phase;
    assign bus.CYCSTART = w_cycstart;
    assign bus.BUSY     = |gnt_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_slot_arbiter
//  Purpose  : Scenario tasks plus randomized traffic against a slot-level
//             reference model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_slot_arbiter;
    localparam int MAXB = 4;

    logic MCK   = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_slot_arbiter_if bus();

    mem_slot_arbiter #(.MAXBURST(MAXB), .BCW(4)) dut (
        .MCK   (MCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 MCK = ~MCK;

    // Reference state: owner index (-1 idle), ack index (-1 none), BLT run length.
    int m_phase;
    int m_owner;
    int m_ack;
    int m_run;
    bit m_cpu_next;

    function automatic void m_reset();
        m_phase    = 0;
        m_owner    = -1;
        m_ack      = -1;
        m_run      = 0;
        m_cpu_next = 1'b1;
    endfunction

    function automatic void m_step();
        bit [3:0] r;
        int       win;
        r     = {bus.CPUREQ, bus.BLTREQ, bus.DSPREQ, bus.VIDREQ};
        m_ack = -1;
        if (m_phase == 2) begin
            if (m_owner >= 0 && r[m_owner]) m_ack = m_owner;
            if (r[0])                                              win = 0;
            else if (m_owner == 2 && bus.BLTLOCK && r[2] && m_run < MAXB) win = 2;
            else if (r[1])                                         win = 1;
            else if (r[2] && r[3]) begin win = m_cpu_next ? 3 : 2; m_cpu_next = (win == 2); end
            else if (r[2])         begin win = 2; m_cpu_next = 1'b1; end
            else if (r[3])         begin win = 3; m_cpu_next = 1'b0; end
            else                                                   win = -1;
            if (win == 2) m_run = (m_owner == 2) ? ((m_run < MAXB) ? m_run + 1 : m_run) : 1;
            else          m_run = 0;
            m_owner = win;
        end
        m_phase = (m_phase + 1) % 3;
    endfunction

    function automatic logic [11:0] m_exp();
        logic [3:0] g;
        logic [3:0] a;
        g = 4'b0000;
        a = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        if (m_ack >= 0)   a[m_ack]   = 1'b1;
        return {2'(m_phase), g, a, (m_phase == 0), (m_owner >= 0)};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.PHASE, bus.GNT, bus.CPUACK, bus.BLTACK, bus.DSPACK, bus.VIDACK,
                bus.CYCSTART, bus.BUSY};
    endfunction

    task automatic tick();
        @(posedge MCK);
        if (!RESET) m_step();
    endtask

    task automatic clear_reqs();
        bus.VIDREQ  = 1'b0;
        bus.DSPREQ  = 1'b0;
        bus.BLTREQ  = 1'b0;
        bus.BLTLOCK = 1'b0;
        bus.CPUREQ  = 1'b0;
    endtask

    // Leaves the bench at a falling edge with the DUT in PHASE 0, idle.
    task automatic do_reset();
        @(negedge MCK);
        RESET = 1'b1;
        clear_reqs();
        m_reset();
        repeat (2) @(negedge MCK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge MCK);
        RESET = 1'b1;
        clear_reqs();
        m_reset();
        #1;
        total++;
        if (obs() !== 12'b00_0000_0000_10)
            $display("FAIL reset_state got=%b want=%b", obs(), 12'b00_0000_0000_10);
        do_reset();
        for (int j = 1; j <= 30; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL idle_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            total++;
            if (bus.PHASE !== 2'(j % 3) || bus.GNT !== 4'b0 || bus.BUSY !== 1'b0) begin
                bad++;
                $display("FAIL idle_phase t=%0d got=%0d/%b want=%0d/0000", j, bus.PHASE, bus.GNT, j % 3);
            end
        end
    endtask

    task automatic test_cpu_single();
        do_reset();
        bus.CPUREQ = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL cpu_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            if (j == 3 || j == 5) begin
                total++;
                if (bus.GNT !== 4'b1000 || bus.CPUACK !== 1'b0) begin
                    bad++;
                    $display("FAIL cpu_grant t=%0d got=%b/%b want=1000/0", j, bus.GNT, bus.CPUACK);
                end
            end
            if (j == 6) begin
                total++;
                if (bus.CPUACK !== 1'b1) begin
                    bad++;
                    $display("FAIL cpu_ack got=%b want=1", bus.CPUACK);
                end
                bus.CPUREQ = 1'b0;
            end
            if (j == 9) begin
                total++;
                if (bus.GNT !== 4'b0000 || bus.CPUACK !== 1'b0) begin
                    bad++;
                    $display("FAIL cpu_release got=%b/%b want=0000/0", bus.GNT, bus.CPUACK);
                end
            end
        end
    endtask

    task automatic test_all_four();
        logic [3:0] want;
        do_reset();
        bus.VIDREQ = 1'b1;
        bus.DSPREQ = 1'b1;
        bus.BLTREQ = 1'b1;
        bus.CPUREQ = 1'b1;
        for (int j = 1; j <= 39; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL all4_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            if (j % 3 == 0) begin
                case (j)
                    3, 6, 9, 12:  want = 4'b0001;
                    15, 18, 21, 24: want = 4'b0010;
                    27, 33, 39:   want = 4'b1000;
                    default:      want = 4'b0100;
                endcase
                total++;
                if (bus.GNT !== want) begin
                    bad++;
                    $display("FAIL all4_order t=%0d got=%b want=%b", j, bus.GNT, want);
                end
            end
            if (j == 12) bus.VIDREQ = 1'b0;
            if (j == 24) bus.DSPREQ = 1'b0;
        end
    endtask

    task automatic test_burst();
        logic [3:0] want;
        do_reset();
        bus.BLTREQ  = 1'b1;
        bus.BLTLOCK = 1'b1;
        bus.CPUREQ  = 1'b1;
        for (int j = 1; j <= 45; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL burst_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            if (j % 3 == 0) begin
                case (j)
                    3, 18, 27, 42: want = 4'b1000;
                    24:            want = 4'b0001;
                    default:       want = 4'b0100;
                endcase
                total++;
                if (bus.GNT !== want) begin
                    bad++;
                    $display("FAIL burst_order t=%0d got=%b want=%b", j, bus.GNT, want);
                end
            end
            if (j == 22) bus.VIDREQ = 1'b1;
            if (j == 24) bus.VIDREQ = 1'b0;
        end
    endtask

    task automatic test_drop_early();
        do_reset();
        bus.CPUREQ = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL drop_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            if (j == 4) bus.CPUREQ = 1'b0;
            if (j == 5) begin
                total++;
                if (bus.GNT !== 4'b1000) begin
                    bad++;
                    $display("FAIL drop_hold got=%b want=1000", bus.GNT);
                end
            end
            if (j == 6) begin
                total++;
                if (bus.CPUACK !== 1'b0 || bus.GNT !== 4'b0000) begin
                    bad++;
                    $display("FAIL drop_noack got=%b/%b want=0/0000", bus.CPUACK, bus.GNT);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.DSPREQ = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            @(negedge MCK);
        end
        total++;
        if (bus.GNT !== 4'b0010 || bus.PHASE !== 2'd1) begin
            bad++;
            $display("FAIL areset_setup got=%b/%0d want=0010/1", bus.GNT, bus.PHASE);
        end
        #2;
        RESET = 1'b1;
        m_reset();
        #1;
        total++;
        if (obs() !== 12'b00_0000_0000_10) begin
            bad++;
            $display("FAIL areset_immediate got=%b want=%b", obs(), 12'b00_0000_0000_10);
        end
        @(negedge MCK);
        RESET = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL areset_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            if (j == 3) begin
                total++;
                if (bus.GNT !== 4'b0010) begin
                    bad++;
                    $display("FAIL areset_regrant got=%b want=0010", bus.GNT);
                end
            end
        end
    endtask

    task automatic test_random();
        bit [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int j = 1; j <= 1500; j++) begin
            tick();
            @(negedge MCK);
            total++;
            if (obs() !== m_exp()) begin
                bad++;
                $display("FAIL rand_model t=%0d got=%b want=%b", j, obs(), m_exp());
            end
            total++;
            if ($countones(bus.GNT) > 1 ||
                $countones({bus.CPUACK, bus.BLTACK, bus.DSPACK, bus.VIDACK}) > 1) begin
                bad++;
                $display("FAIL rand_onehot t=%0d got=%b want<=1hot", j, obs());
            end
            for (int k = 0; k < 4; k++) begin
                if (r[k] && m_ack == k) r[k] = ($urandom_range(0, 9) < 4);
                else if (r[k])          r[k] = ($urandom_range(0, 19) != 0);
                else                    r[k] = ($urandom_range(0, 9) < 3);
            end
            bus.VIDREQ  = r[0] & ($urandom_range(0, 1) == 0);
            bus.DSPREQ  = r[1];
            bus.BLTREQ  = r[2];
            bus.CPUREQ  = r[3];
            bus.BLTLOCK = ($urandom_range(0, 3) != 0);
            r[0]        = bus.VIDREQ;
        end
    endtask

    initial begin
        clear_reqs();
        m_reset();
        test_reset();
        test_cpu_single();
        test_all_four();
        test_burst();
        test_drop_early();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_slot_arbiter.md
Name: mem_slot_arbiter

Overview:
- Shares the main memory bus between four requesters, one bus cycle per 3-tick MCK slot: video fetch, DSP, blitter and CPU.
- Slot timing matches the CCLK divide-by-3 phasing of the clock generator, so each slot is one CCLK period.
- A fixed-priority arbiter with a round-robin pair and a burst lock picks the owner for each slot.
- Gives the memory controller a one-hot grant and each requester a single-tick acknowledge.

Parameters:
- MAXBURST, 4, maximum consecutive slots the blitter may hold via BLTLOCK (legal 1..15).
- BCW, 4, width of the burst counter; must satisfy 2^BCW > MAXBURST.

Ports:
- MCK  in  1  master clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- VIDREQ  in  1  video fetch request; level, held until acknowledged.
- DSPREQ  in  1  DSP request; level.
- BLTREQ  in  1  blitter request; level.
- BLTLOCK  in  1  blitter asks to keep the bus for the next slot.
- CPUREQ  in  1  CPU request; level.
- VIDACK  out  1  one-tick acknowledge to video.
- DSPACK  out  1  one-tick acknowledge to DSP.
- BLTACK  out  1  one-tick acknowledge to blitter.
- CPUACK  out  1  one-tick acknowledge to CPU.
- GNT  out  4  one-hot slot owner {CPU,BLT,DSP,VID}; 0 means idle.
- PHASE  out  2  slot phase 0,1,2.
- CYCSTART  out  1  high while PHASE==0.
- BUSY  out  1  high when GNT!=0.

Behaviour:
- Reset (asynchronous, any time including mid-slot):
  - PHASE=0, GNT=0, all ACK=0, BUSY=0, burst count=0.
  - Round-robin pointer RR set to "CPU next".
  - The slot in progress is abandoned and no ACK is issued for it.
- Phase counter:
  - Sequence 0→1→2→0 on each MCK edge; never takes value 3.
  - CYCSTART and BUSY are combinational decodes of registered state.
- Arbitration:
  - Evaluated combinationally while PHASE==2.
  - The winner is loaded into GNT on the edge where PHASE goes 2→0.
  - GNT is stable for the whole 3-tick slot.
  - Latency from a request first seen high to its grant is 1–3 MCK when it is the top-priority request.
- Priority, highest first:
  1. VIDREQ.
  2. Blitter retention: current owner is BLT, BLTLOCK=1, BLTREQ=1 and burst count < MAXBURST-1.
  3. DSPREQ.
  4. BLT/CPU round robin. If both request, the one RR points to wins and RR then points to the other. If only one requests, it wins and RR points to the other.
  - With no request, GNT=0 (idle slot).
- Burst counter:
  - Incremented when BLT keeps the bus for the next slot.
  - Cleared when the owner changes or the slot is idle.
  - Saturates at MAXBURST-1; the next slot is then arbitrated normally, so the lock cannot starve DSP or CPU.
- Video always preempts a blitter burst. The burst count clears at that point; BLT must re-win arbitration afterwards.
- Acknowledge:
  - xACK = GNT[x] & (PHASE==2) & xREQ, registered so it is high on the tick after PHASE==2 (i.e. during PHASE==0 of the next slot). Exactly one tick wide.
  - A requester that drops REQ before PHASE==2 of its slot gets no ACK. The slot still completes with GNT unchanged.
- Requester rule: REQ may go low on the tick after ACK.
  - A REQ still high at the next arbitration point is treated as a new request.
  - Back-to-back ownership is allowed if REQ stays high and priority permits.
- At most one ACK is high in any tick. GNT is always one-hot or zero.
- A request arriving during PHASE 0 or 1 of an idle slot waits for the next PHASE==2; no mid-slot grant.

Decomposition:
- Shared package holds:
  - Grant bit indices G_VID=0, G_DSP=1, G_BLT=2, G_CPU=3.
  - Phase constants PH_A=0, PH_B=1, PH_C=2.
- One sub-module, slot_phase_counter: mod-3 counter with CYCSTART and an "arbitrate" strobe at PHASE==2.
- Priority logic, round robin, burst counter and ACK registers stay in mem_slot_arbiter.

Test Plan:
- Reset release with no requests → PHASE cycles 0,1,2,0…; GNT=0, BUSY=0, no ACK for 30 ticks.
- CPUREQ raised at PHASE=0 → GNT=4'b1000 from the next PHASE=0, lasting 3 ticks; CPUACK one tick at the following PHASE=0; CPUREQ dropped → GNT=0 next slot.
- All four REQ held high → slot order VID, VID… while VIDREQ is high. Drop VIDREQ → DSP. Drop DSPREQ → CPU, BLT, CPU, BLT alternating; each ACK matches its GNT.
- BLTREQ+BLTLOCK+CPUREQ held, MAXBURST=4 → exactly 4 consecutive BLT slots, then CPU; VIDREQ pulsed during the burst → VID slot next and burst count cleared.
- CPU granted, CPUREQ dropped at PHASE=1 → GNT held to slot end, CPUACK never asserted.
- RESET asserted at PHASE=1 of a DSP slot → GNT, PHASE and ACKs 0 immediately (asynchronously); after release, a DSPREQ still high is granted in the first arbitration.
